tug_light_bar: RTL and testbench
================================

TUG_LIGHT_BAR -- requirements
Module: tug_light_bar

Interface
REQ-001 The parameter list SHALL be exactly:
  - N_LIGHTS, default 9: number of playfield lights; odd, 3..31.
  - WIN_SCORE, default 7: round wins needed to take the match; 1..15.
REQ-002 The ports SHALL be exactly:
  - clk  in  1  sole clock; all state changes on its rising edge.
  - reset  in  1  synchronous, active-low reset; asserted when 0.
  - L  in  1  left key level, already synchronised to clk; 1 = pressed.
  - R  in  1  right key level, already synchronised to clk; 1 = pressed.
  - nextRound  in  1  level; 1 starts the next round after a round win.
  - lights  out  N_LIGHTS  one-hot playfield; bit N_LIGHTS-1 is leftmost.
  - winL  out  1  left player won the current round.
  - winR  out  1  right player won the current round.
  - scoreL  out  4  left round-win count.
  - scoreR  out  4  right round-win count.
  - matchOver  out  1  a player has reached WIN_SCORE.

Function
REQ-003 A press SHALL be the rising edge of L or R, i.e. key = 1 this cycle and 0 the previous cycle; holding a key SHALL count as one press.
REQ-004 When both presses occur in the same cycle they SHALL cancel, with no movement and no win.
REQ-005 The FSM SHALL have four states: PLAY, WON_L, WON_R and MATCH_DONE.
REQ-006 In PLAY, a position register pos (0..N_LIGHTS-1) SHALL drive lights as one-hot with bit pos set.
REQ-007 In PLAY:
  - A lone L press with pos < N_LIGHTS-1 SHALL set pos = pos+1 on the next cycle.
  - A lone R press with pos > 0 SHALL set pos = pos-1 on the next cycle.
REQ-008 In PLAY:
  - A lone L press with pos = N_LIGHTS-1 SHALL increment scoreL and enter WON_L on the next cycle.
  - A lone R press with pos = 0 SHALL increment scoreR and enter WON_R on the next cycle.
REQ-009 In WON_L and WON_R:
  - lights SHALL be all zero.
  - winL = 1 only in WON_L; winR = 1 only in WON_R.
  - L and R SHALL be ignored.
REQ-010 In WON_L/WON_R with nextRound = 1, the FSM SHALL enter PLAY on the next cycle with pos = (N_LIGHTS-1)/2.
REQ-011 If a score increment makes that score equal WIN_SCORE, the FSM SHALL enter MATCH_DONE instead of WON_x.
REQ-012 In MATCH_DONE:
  - matchOver SHALL be 1.
  - the winner's winL/winR SHALL stay 1.
  - lights SHALL be all zero.
  - nextRound, L and R SHALL be ignored.
  - Only reset exits this state.
REQ-013 nextRound asserted during PLAY SHALL recentre pos to (N_LIGHTS-1)/2 on the next cycle without changing scores; it SHALL take priority over a press in the same cycle.
REQ-014 Scores SHALL never exceed WIN_SCORE and SHALL never wrap.
REQ-015 Every output SHALL be a direct function of registered state (Moore outputs); press-to-output latency SHALL be exactly one cycle.

Reset
REQ-016 While reset = 0 at a clock edge, the next state SHALL be:
  - PLAY, with pos = (N_LIGHTS-1)/2;
  - scoreL = scoreR = 0;
  - winL = winR = matchOver = 0;
  - both edge-detect history bits = 1, so a key held through reset does not register a press.
REQ-017 Reset asserted mid-round, in WON_x or in MATCH_DONE SHALL have the same effect as REQ-016 and SHALL take priority over all other inputs.

Structure
REQ-018 The package tug_pkg SHALL hold:
  - the state enum (PLAY, WON_L, WON_R, MATCH_DONE);
  - the default N_LIGHTS and WIN_SCORE;
  - the score width constant (4).
REQ-019 Rising-edge detection SHALL be a sub-module key_edge, instantiated once each for L and R, with ports clk, reset, key and press.
REQ-020 The total implementation SHALL be 120-400 lines of RTL.

Verification (N_LIGHTS=5, WIN_SCORE=2)
REQ-021 Reset then idle SHALL give lights=00100, scores 0/0 and all flags 0.
REQ-022 Two single-cycle L pulses SHALL give lights=01000 then 10000; a third L pulse SHALL give winL=1, scoreL=1, lights=00000; nextRound for 1 cycle SHALL then give lights=00100 and winL=0.
REQ-023 L held for 6 cycles SHALL move lights once only (01000); L and R rising in the same cycle SHALL leave lights unchanged.
REQ-024 Two right round wins SHALL give scoreR=2, matchOver=1 and winR=1; further nextRound, L and R activity SHALL change nothing; reset=0 SHALL then restore the state of REQ-021.
REQ-025 Reset asserted while lights=00010 and L held SHALL give lights=00100 after release, with no press counted from the held key.

Source files
------------

// File: rtl/tug_pkg.sv
// Shared types and defaults for the tug-of-war light bar.
package tug_pkg;

  localparam int unsigned DEFAULT_N_LIGHTS  = 9;
  localparam int unsigned DEFAULT_WIN_SCORE = 7;
  localparam int unsigned SCORE_W           = 4;

  typedef enum logic [1:0] {
    PLAY       = 2'd0,
    WON_L      = 2'd1,
    WON_R      = 2'd2,
    MATCH_DONE = 2'd3
  } state_t;

endpackage

// File: rtl/key_edge.sv
// Rising-edge detector for one synchronised key level.
module key_edge (
  input  logic clk,
  input  logic reset,
  input  logic key,
  output logic press
);

  logic prev;

  // History resets high so a key held through reset is not seen as a press.
  always_ff @(posedge clk) begin
    if (!reset) prev <= 1'b1;
    else        prev <= key;
  end

  assign press = key & ~prev;

endmodule

// File: rtl/tug_light_bar.sv
// Two-player tug-of-war light bar: presses move a lit spot, edge hits win rounds.
module tug_light_bar
  import tug_pkg::*;
#(
  parameter int unsigned N_LIGHTS  = DEFAULT_N_LIGHTS,
  parameter int unsigned WIN_SCORE = DEFAULT_WIN_SCORE
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                L,
  input  logic                R,
  input  logic                nextRound,
  output logic [N_LIGHTS-1:0] lights,
  output logic                winL,
  output logic                winR,
  output logic [SCORE_W-1:0]  scoreL,
  output logic [SCORE_W-1:0]  scoreR,
  output logic                matchOver
);

  localparam int unsigned       POS_W  = $clog2(N_LIGHTS);
  localparam logic [POS_W-1:0]  CENTER = POS_W'((N_LIGHTS - 1) / 2);
  localparam logic [POS_W-1:0]  LAST   = POS_W'(N_LIGHTS - 1);
  localparam logic [SCORE_W-1:0] WIN   = SCORE_W'(WIN_SCORE);

  state_t             state, state_n;
  logic [POS_W-1:0]   pos, pos_n;
  logic [SCORE_W-1:0] score_l_n, score_r_n;
  logic               press_l, press_r;
  logic               lone_l, lone_r;

  key_edge u_edge_l (.clk(clk), .reset(reset), .key(L), .press(press_l));
  key_edge u_edge_r (.clk(clk), .reset(reset), .key(R), .press(press_r));

  assign lone_l = press_l & ~press_r;
  assign lone_r = press_r & ~press_l;

  // Next-state logic; simultaneous presses cancel, nextRound beats a press.
  always_comb begin
    state_n   = state;
    pos_n     = pos;
    score_l_n = scoreL;
    score_r_n = scoreR;
    case (state)
      PLAY: begin
        if (nextRound) begin
          pos_n = CENTER;
        end else if (lone_l) begin
          if (pos == LAST) begin
            score_l_n = scoreL + SCORE_W'(1);
            state_n   = (score_l_n == WIN) ? MATCH_DONE : WON_L;
          end else begin
            pos_n = pos + POS_W'(1);
          end
        end else if (lone_r) begin
          if (pos == '0) begin
            score_r_n = scoreR + SCORE_W'(1);
            state_n   = (score_r_n == WIN) ? MATCH_DONE : WON_R;
          end else begin
            pos_n = pos - POS_W'(1);
          end
        end
      end
      WON_L, WON_R: begin
        if (nextRound) begin
          state_n = PLAY;
          pos_n   = CENTER;
        end
      end
      default: ;
    endcase
  end

  // State and Moore outputs registered together from the next-state values.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= PLAY;
      pos       <= CENTER;
      scoreL    <= '0;
      scoreR    <= '0;
      lights    <= N_LIGHTS'(1) << CENTER;
      winL      <= 1'b0;
      winR      <= 1'b0;
      matchOver <= 1'b0;
    end else begin
      state     <= state_n;
      pos       <= pos_n;
      scoreL    <= score_l_n;
      scoreR    <= score_r_n;
      lights    <= (state_n == PLAY) ? (N_LIGHTS'(1) << pos_n) : '0;
      winL      <= (state_n == WON_L) || (state_n == MATCH_DONE && score_l_n == WIN);
      winR      <= (state_n == WON_R) || (state_n == MATCH_DONE && score_r_n == WIN);
      matchOver <= (state_n == MATCH_DONE);
    end
  end

endmodule

// File: tb/tb_tug_light_bar.sv
// Randomised self-checking bench for tug_light_bar against a rule-level model.
module tb_tug_light_bar;

  localparam int NL  = 5;
  localparam int WS  = 2;
  localparam int MID = (NL - 1) / 2;

  logic          clk;
  logic          reset;
  logic          L, R, nextRound;
  logic [NL-1:0] lights;
  logic          winL, winR, matchOver;
  logic [3:0]    scoreL, scoreR;

  tug_light_bar #(.N_LIGHTS(NL), .WIN_SCORE(WS)) dut (
    .clk(clk), .reset(reset), .L(L), .R(R), .nextRound(nextRound),
    .lights(lights), .winL(winL), .winR(winR),
    .scoreL(scoreL), .scoreR(scoreR), .matchOver(matchOver)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Model: spot position, per-player scores, round winner (0 none, 1 left, 2 right), match flag.
  int m_pos, m_sl, m_sr, m_winner;
  bit m_over, m_prev_l, m_prev_r;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
  endtask

  task automatic model_update(input bit l, input bit r, input bit nr, input bit rs);
    bit pl, pr;
    if (!rs) begin
      m_pos = MID; m_sl = 0; m_sr = 0; m_winner = 0; m_over = 0;
      m_prev_l = 1; m_prev_r = 1;
    end else begin
      pl = l && !m_prev_l;
      pr = r && !m_prev_r;
      m_prev_l = l;
      m_prev_r = r;
      if (m_over) begin
        // frozen until reset
      end else if (m_winner != 0) begin
        if (nr) begin m_winner = 0; m_pos = MID; end
      end else if (nr) begin
        m_pos = MID;
      end else if (pl && !pr) begin
        if (m_pos == NL - 1) begin
          m_sl++; m_winner = 1;
          if (m_sl == WS) m_over = 1;
        end else m_pos++;
      end else if (pr && !pl) begin
        if (m_pos == 0) begin
          m_sr++; m_winner = 2;
          if (m_sr == WS) m_over = 1;
        end else m_pos--;
      end
    end
  endtask

  task automatic compare_all();
    logic [31:0] exp_lights;
    exp_lights = (m_winner == 0 && !m_over) ? (32'd1 << m_pos) : 32'd0;
    check("lights",    32'(lights),    exp_lights);
    check("winL",      32'(winL),      32'(m_winner == 1));
    check("winR",      32'(winR),      32'(m_winner == 2));
    check("scoreL",    32'(scoreL),    32'(m_sl));
    check("scoreR",    32'(scoreR),    32'(m_sr));
    check("matchOver", 32'(matchOver), 32'(m_over));
  endtask

  task automatic step(input bit l, input bit r, input bit nr, input bit rs);
    @(negedge clk);
    L = l; R = r; nextRound = nr; reset = rs;
    @(posedge clk);
    model_update(l, r, nr, rs);
    #1;
    compare_all();
  endtask

  initial begin
    reset = 1'b0; L = 1'b0; R = 1'b0; nextRound = 1'b0;

    // Reset then idle
    step(0, 0, 0, 0);
    step(0, 0, 0, 1);
    check("idle_lights", 32'(lights), 32'b00100);
    check("idle_flags",  32'({winL, winR, matchOver, scoreL, scoreR}), 32'd0);

    // Left pulses walk to the edge and win a round
    step(1, 0, 0, 1); check("l1_lights", 32'(lights), 32'b01000);
    step(0, 0, 0, 1);
    step(1, 0, 0, 1); check("l2_lights", 32'(lights), 32'b10000);
    step(0, 0, 0, 1);
    step(1, 0, 0, 1); check("lwin", 32'({winL, scoreL, lights}), {23'd0, 1'b1, 4'd1, 5'b00000});
    step(0, 0, 1, 1); check("next_round", 32'({winL, lights}), {26'd0, 1'b0, 5'b00100});

    // Held key moves once; simultaneous presses cancel
    for (int i = 0; i < 6; i++) step(1, 0, 0, 1);
    check("held_lights", 32'(lights), 32'b01000);
    step(0, 0, 0, 1);
    step(1, 1, 0, 1); check("cancel_lights", 32'(lights), 32'b01000);
    step(0, 0, 0, 1);

    // Two right round wins end the match
    step(0, 0, 1, 1);
    for (int rnd = 0; rnd < 2; rnd++) begin
      for (int i = 0; i < 3; i++) begin
        step(0, 1, 0, 1);
        step(0, 0, 0, 1);
      end
      if (rnd == 0) step(0, 0, 1, 1);
    end
    check("match", 32'({matchOver, winR, scoreR}), {26'd0, 1'b1, 1'b1, 4'd2});
    for (int i = 0; i < 8; i++) step(bit'(i[0]), bit'(i[1]), bit'(i[2]), 1);
    check("match_frozen", 32'({matchOver, winR, scoreR, lights}), {21'd0, 1'b1, 1'b1, 4'd2, 5'b00000});
    step(0, 0, 0, 0);
    step(0, 0, 0, 1);
    check("after_reset", 32'({matchOver, winR, scoreR, lights}), {21'd0, 1'b0, 1'b0, 4'd0, 5'b00100});

    // Reset with L held registers no press
    step(0, 1, 0, 1); check("pos1", 32'(lights), 32'b00010);
    step(1, 0, 0, 0);
    step(1, 0, 0, 1);
    step(0, 0, 0, 1); check("held_reset", 32'(lights), 32'b00100);

    // Random play
    for (int i = 0; i < 3000; i++) begin
      step(bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)),
           $urandom_range(0, 15) == 0, $urandom_range(0, 299) != 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
